id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode stage (control unit + register file) and the execute stage.
- Latches the decoded control word, operands and register indices every cycle.
- Detects load-use hazards against the instruction it currently holds, stalls IF/ID and inserts a bubble.
- Honours branch-taken flush and a global freeze. Keeps a saturating bubble counter for performance checks.

Parameters:
- DW, 32, datapath width (PC, operands, store value).
- RW, 5, register index width.
- CW, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- freeze  in  1  global hold (memory wait); all state holds
- flush  in  1  branch/jump taken in EXE; kills the instruction entering EXE
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  PC+4 of the ID instruction
- id_exec_cmd  in  4  ALU command
- id_mem_r_en, id_mem_w_en, id_wb_en, id_is_imm, id_st_or_bne, id_is_br, id_br_type, id_is_jmp  in  1 each  control bits
- id_val1, id_val2, id_st_val  in  DW each  operands and store data
- id_src1, id_src2, id_dest  in  RW each  register indices
- id_src2_used  in  1  src2 is really read (R-type, store, bne/beq)
- exe_valid  out  1  EXE holds a real instruction
- exe_pc, exe_val1, exe_val2, exe_st_val  out  DW each  registered copies
- exe_exec_cmd  out  4  registered copy
- exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_is_imm, exe_st_or_bne, exe_is_br, exe_br_type, exe_is_jmp  out  1 each  registered copies
- exe_src1, exe_src2, exe_dest  out  RW each  registered copies (forwarding unit uses src1/src2)
- hazard_stall  out  1  combinational; hold PC and IF/ID register this cycle
- bubble_cnt  out  CW  saturating count of hazard bubbles inserted

Behaviour:
- Reset (async, immediate): every output register is 0, exe_valid=0, bubble_cnt=0. hazard_stall evaluates to 0 because exe_valid=0.
- Hazard (combinational): hazard = exe_valid & exe_mem_r_en & (exe_dest!=0) & id_valid & ((exe_dest==id_src1) | (id_src2_used & exe_dest==id_src2)).
- hazard_stall = hazard & ~flush. A flush squashes the ID instruction anyway, so no stall is raised.
- Next-state priority on each clk edge, highest first:
  1. freeze=1: all registers hold, including bubble_cnt. hazard_stall is still driven, but no bubble is inserted.
  2. flush=1: load a bubble (exe_valid=0, all control bits and exe_exec_cmd = 0, exe_dest=0). Data/PC fields do not matter. bubble_cnt is not incremented.
  3. hazard=1: load a bubble. bubble_cnt increments, saturating at 2^CW-1.
  4. Otherwise: load all id_* fields. exe_valid=id_valid. If id_valid=0, all control bits load as 0.
- The only latency is one cycle, ID to EXE. There is no combinational path from id_* to exe_* outputs.
- After a bubble, the stalled ID instruction is presented again next cycle. The loaded instruction is no longer a load, so hazard drops and the instruction advances. A load-use pair therefore costs exactly one bubble.
- Store (mem_w_en) or branch in EXE never triggers a hazard. Only exe_mem_r_en does.
- Register 0 as exe_dest never triggers a hazard.
- A hazard on src2 with id_src2_used=0 (immediate form) is ignored.
- Simultaneous freeze and flush: freeze wins. The flush source holds its request until freeze drops.
- Simultaneous flush and hazard: flush wins, hazard_stall=0, no count.
- Reset asserted mid-stall: outputs clear immediately. hazard_stall drops in the same cycle.

Test Plan:
- Normal flow: id_valid=1, id_exec_cmd=4'd1, id_wb_en=1, id_val1=32'h10, id_dest=5 -> next edge exe_valid=1, exe_exec_cmd=1, exe_val1=32'h10, exe_dest=5. Outputs were 0 before the edge.
- Load-use: EXE holds mem_r_en=1, dest=7; ID src1=7 -> hazard_stall=1. Next edge exe_valid=0, control=0, bubble_cnt=1. Following edge loads the ID instruction and hazard_stall=0.
- Non-hazards: EXE load dest=0 with ID src1=0 -> no stall. EXE load dest=9, ID src2=9 with id_src2_used=0 -> no stall. EXE store dest=9, ID src1=9 -> no stall.
- Flush vs hazard: load-use condition plus flush=1 -> hazard_stall=0. Next edge bubble, bubble_cnt unchanged.
- Freeze: freeze=1 for 3 cycles while ID inputs change and hazard is present -> exe_* and bubble_cnt unchanged. Release loads the bubble as per priority.
- Saturation/reset: CW=2, force 5 hazard bubbles -> bubble_cnt=3. Assert rst mid-cycle -> all outputs 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// id_exe_stage_reg
//
// Pipeline register between decode (control unit + register file) and
// execute. Every cycle it latches the decoded control word, operands and
// register indices. It also checks for a load-use hazard between the
// instruction in EXE and the one in ID. On a hazard it stalls IF/ID and
// inserts a bubble. It honours a branch flush and a global freeze, and
// keeps a saturating count of hazard bubbles.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   freeze              hold every register (memory wait)
//   flush               kill the instruction entering EXE (branch taken)
//   id_*                decoded instruction presented by the ID stage
//   exe_*               registered copy seen by the EXE stage
//   hazard_stall        combinational; hold PC and IF/ID this cycle
//   bubble_cnt          saturating count of hazard bubbles inserted
// ---------------------------------------------------------------------------
module id_exe_stage_reg #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_pc,
   input  logic [3:0]    id_exec_cmd,
   input  logic          id_mem_r_en,
   input  logic          id_mem_w_en,
   input  logic          id_wb_en,
   input  logic          id_is_imm,
   input  logic          id_st_or_bne,
   input  logic          id_is_br,
   input  logic          id_br_type,
   input  logic          id_is_jmp,
   input  logic [DW-1:0] id_val1,
   input  logic [DW-1:0] id_val2,
   input  logic [DW-1:0] id_st_val,
   input  logic [RW-1:0] id_src1,
   input  logic [RW-1:0] id_src2,
   input  logic [RW-1:0] id_dest,
   input  logic          id_src2_used,
   output logic          exe_valid,
   output logic [DW-1:0] exe_pc,
   output logic [DW-1:0] exe_val1,
   output logic [DW-1:0] exe_val2,
   output logic [DW-1:0] exe_st_val,
   output logic [3:0]    exe_exec_cmd,
   output logic          exe_mem_r_en,
   output logic          exe_mem_w_en,
   output logic          exe_wb_en,
   output logic          exe_is_imm,
   output logic          exe_st_or_bne,
   output logic          exe_is_br,
   output logic          exe_br_type,
   output logic          exe_is_jmp,
   output logic [RW-1:0] exe_src1,
   output logic [RW-1:0] exe_src2,
   output logic [RW-1:0] exe_dest,
   output logic          hazard_stall,
   output logic [CW-1:0] bubble_cnt
);

   // Control word: everything a bubble must clear.
   typedef struct packed {
      logic          valid;
      logic [3:0]    exec_cmd;
      logic          mem_r_en;
      logic          mem_w_en;
      logic          wb_en;
      logic          is_imm;
      logic          st_or_bne;
      logic          is_br;
      logic          br_type;
      logic          is_jmp;
      logic [RW-1:0] src1;
      logic [RW-1:0] src2;
      logic [RW-1:0] dest;
   } ctrl_t;

   typedef struct packed {
      logic [DW-1:0] pc;
      logic [DW-1:0] val1;
      logic [DW-1:0] val2;
      logic [DW-1:0] st_val;
   } data_t;

   ctrl_t         ctrl_q, ctrl_d;
   data_t         data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hazard;

   // Only a valid load in EXE can create a load-use hazard; r0 never does,
   // and src2 only matters when the ID instruction really reads it.
   assign hazard = ctrl_q.valid & ctrl_q.mem_r_en & (ctrl_q.dest != '0) & id_valid &
                   ((ctrl_q.dest == id_src1) | (id_src2_used & (ctrl_q.dest == id_src2)));

   // A flush squashes the ID instruction anyway, so no stall is needed.
   assign hazard_stall = hazard & ~flush;

   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      cnt_d  = cnt_q;
      if (!freeze) begin
         // Data fields are don't-care in a bubble; loading them always keeps
         // the data path free of control muxing.
         data_d.pc     = id_pc;
         data_d.val1   = id_val1;
         data_d.val2   = id_val2;
         data_d.st_val = id_st_val;
         if (flush) begin
            ctrl_d = '0;
         end else if (hazard) begin
            ctrl_d = '0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end else begin
            ctrl_d.valid     = id_valid;
            ctrl_d.exec_cmd  = id_valid ? id_exec_cmd : 4'd0;
            ctrl_d.mem_r_en  = id_valid & id_mem_r_en;
            ctrl_d.mem_w_en  = id_valid & id_mem_w_en;
            ctrl_d.wb_en     = id_valid & id_wb_en;
            ctrl_d.is_imm    = id_valid & id_is_imm;
            ctrl_d.st_or_bne = id_valid & id_st_or_bne;
            ctrl_d.is_br     = id_valid & id_is_br;
            ctrl_d.br_type   = id_valid & id_br_type;
            ctrl_d.is_jmp    = id_valid & id_is_jmp;
            ctrl_d.src1      = id_src1;
            ctrl_d.src2      = id_src2;
            ctrl_d.dest      = id_dest;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q <= '0;
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         ctrl_q <= ctrl_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign exe_valid     = ctrl_q.valid;
   assign exe_exec_cmd  = ctrl_q.exec_cmd;
   assign exe_mem_r_en  = ctrl_q.mem_r_en;
   assign exe_mem_w_en  = ctrl_q.mem_w_en;
   assign exe_wb_en     = ctrl_q.wb_en;
   assign exe_is_imm    = ctrl_q.is_imm;
   assign exe_st_or_bne = ctrl_q.st_or_bne;
   assign exe_is_br     = ctrl_q.is_br;
   assign exe_br_type   = ctrl_q.br_type;
   assign exe_is_jmp    = ctrl_q.is_jmp;
   assign exe_src1      = ctrl_q.src1;
   assign exe_src2      = ctrl_q.src2;
   assign exe_dest      = ctrl_q.dest;
   assign exe_pc        = data_q.pc;
   assign exe_val1      = data_q.val1;
   assign exe_val2      = data_q.val2;
   assign exe_st_val    = data_q.st_val;
   assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_stage_reg
//
// Directed bench for id_exe_stage_reg, instantiated with CW=2 so that the
// bubble counter saturates at 3.
// ---------------------------------------------------------------------------
module tb_id_exe_stage_reg;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          freeze, flush, id_valid;
   logic [DW-1:0] id_pc, id_val1, id_val2, id_st_val;
   logic [3:0]    id_exec_cmd;
   logic          id_mem_r_en, id_mem_w_en, id_wb_en, id_is_imm;
   logic          id_st_or_bne, id_is_br, id_br_type, id_is_jmp;
   logic [RW-1:0] id_src1, id_src2, id_dest;
   logic          id_src2_used;
   logic          exe_valid;
   logic [DW-1:0] exe_pc, exe_val1, exe_val2, exe_st_val;
   logic [3:0]    exe_exec_cmd;
   logic          exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_is_imm;
   logic          exe_st_or_bne, exe_is_br, exe_br_type, exe_is_jmp;
   logic [RW-1:0] exe_src1, exe_src2, exe_dest;
   logic          hazard_stall;
   logic [CW-1:0] bubble_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   id_exe_stage_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_exec_cmd(id_exec_cmd),
      .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_wb_en(id_wb_en),
      .id_is_imm(id_is_imm), .id_st_or_bne(id_st_or_bne), .id_is_br(id_is_br),
      .id_br_type(id_br_type), .id_is_jmp(id_is_jmp),
      .id_val1(id_val1), .id_val2(id_val2), .id_st_val(id_st_val),
      .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
      .id_src2_used(id_src2_used),
      .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_val1(exe_val1),
      .exe_val2(exe_val2), .exe_st_val(exe_st_val), .exe_exec_cmd(exe_exec_cmd),
      .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en),
      .exe_is_imm(exe_is_imm), .exe_st_or_bne(exe_st_or_bne), .exe_is_br(exe_is_br),
      .exe_br_type(exe_br_type), .exe_is_jmp(exe_is_jmp),
      .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
      .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one instruction in ID; unlisted control bits are 0.
   task automatic set_id(input logic v, input logic [3:0] cmd, input logic rd,
                         input logic wr, input logic wb, input logic [RW-1:0] s1,
                         input logic [RW-1:0] s2, input logic used,
                         input logic [RW-1:0] d, input logic [DW-1:0] v1);
      id_valid = v;     id_exec_cmd = cmd; id_mem_r_en = rd; id_mem_w_en = wr;
      id_wb_en = wb;    id_src1 = s1;      id_src2 = s2;     id_src2_used = used;
      id_dest = d;      id_val1 = v1;      id_val2 = 32'h22; id_st_val = 32'h33;
      id_pc = 32'h100;  id_is_imm = 1'b0;  id_st_or_bne = 1'b0; id_is_br = 1'b0;
      id_br_type = 1'b0; id_is_jmp = 1'b0;
      #1;
   endtask

   // Advance one edge and settle for sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0;
      set_id(0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_valid", {63'd0, exe_valid}, 64'd0);
      chk("reset_cnt", {62'd0, bubble_cnt}, 64'd0);
      chk("reset_stall", {63'd0, hazard_stall}, 64'd0);
      chk("reset_pc", {32'd0, exe_pc}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Normal flow: outputs still 0 before the edge, loaded after it.
      @(posedge clk); #1;
      set_id(1, 4'd1, 0, 0, 1, 5'd1, 5'd2, 1, 5'd5, 32'h10);
      chk("pre_edge_valid", {63'd0, exe_valid}, 64'd0);
      tick();
      chk("norm_valid", {63'd0, exe_valid}, 64'd1);
      chk("norm_cmd", {60'd0, exe_exec_cmd}, 64'd1);
      chk("norm_val1", {32'd0, exe_val1}, 64'h10);
      chk("norm_dest", {59'd0, exe_dest}, 64'd5);
      chk("norm_wb", {63'd0, exe_wb_en}, 64'd1);
      chk("norm_pc", {32'd0, exe_pc}, 64'h100);

      // Invalid ID slot loads zero control bits.
      set_id(0, 4'd3, 0, 0, 1, 5'd1, 5'd2, 1, 5'd6, 32'h11);
      tick();
      chk("inv_valid", {63'd0, exe_valid}, 64'd0);
      chk("inv_wb", {63'd0, exe_wb_en}, 64'd0);
      chk("inv_cmd", {60'd0, exe_exec_cmd}, 64'd0);

      // Load-use on src1.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd7, 32'h0);
      tick();
      set_id(1, 4'd2, 0, 0, 1, 5'd7, 5'd3, 1, 5'd8, 32'h44);
      chk("lu_stall", {63'd0, hazard_stall}, 64'd1);
      tick();
      chk("lu_bub_valid", {63'd0, exe_valid}, 64'd0);
      chk("lu_bub_cmd", {60'd0, exe_exec_cmd}, 64'd0);
      chk("lu_bub_wb", {63'd0, exe_wb_en}, 64'd0);
      chk("lu_bub_dest", {59'd0, exe_dest}, 64'd0);
      chk("lu_cnt", {62'd0, bubble_cnt}, 64'd1);
      chk("lu_stall_drop", {63'd0, hazard_stall}, 64'd0);
      tick();
      chk("lu_adv_valid", {63'd0, exe_valid}, 64'd1);
      chk("lu_adv_dest", {59'd0, exe_dest}, 64'd8);
      chk("lu_adv_cmd", {60'd0, exe_exec_cmd}, 64'd2);
      chk("lu_adv_stall", {63'd0, hazard_stall}, 64'd0);

      // Load with dest r0 never stalls.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd0, 32'h0);
      tick();
      set_id(1, 4'd2, 0, 0, 1, 5'd0, 5'd0, 1, 5'd4, 32'h0);
      chk("r0_nostall", {63'd0, hazard_stall}, 64'd0);

      // src2 match ignored when src2 is not used; honoured when it is.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd9, 32'h0);
      tick();
      set_id(1, 4'd2, 0, 0, 1, 5'd3, 5'd9, 0, 5'd4, 32'h0);
      chk("src2_unused", {63'd0, hazard_stall}, 64'd0);
      set_id(1, 4'd2, 0, 0, 1, 5'd3, 5'd9, 1, 5'd4, 32'h0);
      chk("src2_used", {63'd0, hazard_stall}, 64'd1);

      // Store in EXE never stalls.
      set_id(1, 4'd0, 0, 1, 0, 5'd3, 5'd1, 1, 5'd9, 32'h0);
      tick();
      chk("store_loaded", {63'd0, exe_mem_w_en}, 64'd1);
      set_id(1, 4'd2, 0, 0, 1, 5'd9, 5'd9, 1, 5'd4, 32'h0);
      chk("store_nostall", {63'd0, hazard_stall}, 64'd0);

      // Flush beats hazard: no stall, bubble, no count.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd7, 32'h0);
      tick();
      set_id(1, 4'd2, 0, 0, 1, 5'd7, 5'd3, 1, 5'd8, 32'h0);
      flush = 1'b1; #1;
      chk("flush_stall", {63'd0, hazard_stall}, 64'd0);
      tick();
      flush = 1'b0;
      chk("flush_valid", {63'd0, exe_valid}, 64'd0);
      chk("flush_cnt", {62'd0, bubble_cnt}, 64'd1);

      // Freeze for 3 cycles with a hazard present and ID changing.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd7, 32'h0);
      tick();
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_id(1, 4'(i + 3), 0, 0, 1, 5'd7, 5'd3, 1, 5'd8, 32'(i));
         chk("frz_stall", {63'd0, hazard_stall}, 64'd1);
         tick();
         chk("frz_valid", {63'd0, exe_valid}, 64'd1);
         chk("frz_rd", {63'd0, exe_mem_r_en}, 64'd1);
         chk("frz_dest", {59'd0, exe_dest}, 64'd7);
         chk("frz_cnt", {62'd0, bubble_cnt}, 64'd1);
      end
      freeze = 1'b0;
      tick();
      chk("frz_rel_valid", {63'd0, exe_valid}, 64'd0);
      chk("frz_rel_cnt", {62'd0, bubble_cnt}, 64'd2);

      // Four more load-use pairs: 2 -> 3 then held at 3.
      for (int i = 0; i < 4; i++) begin
         set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd7, 32'h0);
         tick();
         set_id(1, 4'd2, 0, 0, 1, 5'd7, 5'd3, 1, 5'd8, 32'h0);
         tick();
         chk("sat_cnt", {62'd0, bubble_cnt}, 64'd3);
      end

      // Async reset in the middle of a stall cycle.
      set_id(1, 4'd0, 1, 0, 1, 5'd1, 5'd2, 0, 5'd7, 32'h0);
      tick();
      set_id(1, 4'd2, 0, 0, 1, 5'd7, 5'd3, 1, 5'd8, 32'h0);
      chk("pre_rst_stall", {63'd0, hazard_stall}, 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", {63'd0, exe_valid}, 64'd0);
      chk("arst_stall", {63'd0, hazard_stall}, 64'd0);
      chk("arst_cnt", {62'd0, bubble_cnt}, 64'd0);
      chk("arst_dest", {59'd0, exe_dest}, 64'd0);
      chk("arst_rd", {63'd0, exe_mem_r_en}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
